// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA timing generator with blanked, registered RGB/sync outputs.
// Latency: x/y are combinational from the counters; rgb/syncs/video_active/frame_tick lag them by 1 clock.
// Backpressure: none, free-running at the pixel clock; color must answer x/y in the same cycle.
//
// Ports:
//   CLOCK_25      pixel clock (25 MHz)
//   RESET_N       asynchronous active-low reset
//   color[2:0]    pixel colour for the current (x, y), bit2=R bit1=G bit0=B
//   x[11:0]       1-based column in active video, 0 in blanking
//   y[11:0]       1-based row in active video, 0 in blanking
//   rgb[2:0]      registered colour, forced to 0 outside active video
//   hsync_n       registered horizontal sync, active low
//   vsync_n       registered vertical sync, active low
//   video_active  registered, high while rgb carries visible pixels
//   frame_tick    registered one-cycle pulse at the start of vertical blanking
//
// Build option: define FRAME_TICK_EN to build the frame_tick generator; otherwise
// frame_tick is tied low and its register/comparator are not built.

`timescale 1ns/1ps

module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        CLOCK_25,
    input  logic        RESET_N,
    input  logic [2:0]  color,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic [2:0]  rgb,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        video_active,
    output logic        frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 12-bit views of the timing boundaries so every compare is width-matched.
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_FIRST = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] VS_FIRST = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;

    logic        active;
    logic        hs_win;
    logic        vs_win;

    logic [2:0]  rgb_q, rgb_d;
    logic        hsync_n_q, hsync_n_d;
    logic        vsync_n_q, vsync_n_d;
    logic        video_active_q, video_active_d;

    // Pixel/line counters: v_cnt advances on the same cycle h_cnt wraps.
    always_comb begin
        h_cnt_d = h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + 12'd1;
            end
        end
    end

    // Timing decode from the counter registers only.
    always_comb begin
        active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs_win = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
        vs_win = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
    end

    // Coordinates are 1-based so 0 can unambiguously mean "blanking".
    always_comb begin
        x = '0;
        y = '0;
        if (active) begin
            x = h_cnt_q + 12'd1;
            y = v_cnt_q + 12'd1;
        end
    end

    // Output stage inputs: everything is registered once so pins stay aligned.
    always_comb begin
        rgb_d          = active ? color : 3'b000;
        hsync_n_d      = ~hs_win;
        vsync_n_d      = ~vs_win;
        video_active_d = active;
    end

    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            h_cnt_q        <= '0;
            v_cnt_q        <= '0;
            rgb_q          <= 3'b000;
            hsync_n_q      <= 1'b1;
            vsync_n_q      <= 1'b1;
            video_active_q <= 1'b0;
        end else begin
            h_cnt_q        <= h_cnt_d;
            v_cnt_q        <= v_cnt_d;
            rgb_q          <= rgb_d;
            hsync_n_q      <= hsync_n_d;
            vsync_n_q      <= vsync_n_d;
            video_active_q <= video_active_d;
        end
    end

    assign rgb          = rgb_q;
    assign hsync_n      = hsync_n_q;
    assign vsync_n      = vsync_n_q;
    assign video_active = video_active_q;

`ifdef FRAME_TICK_EN
    // Tick marks the first blanking line so game logic can update off-screen.
    logic frame_tick_q, frame_tick_d;

    always_comb begin
        frame_tick_d = (h_cnt_q == 12'd0) && (v_cnt_q == V_ACT);
    end

    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= frame_tick_d;
        end
    end

    assign frame_tick = frame_tick_q;
`else
    assign frame_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: checks two vga_sync_gen instances, one with the standard 640x480 timing
// and one with a shrunken raster so whole frames fit in a short run, against a model that
// derives every expected output from the number of clock edges since reset release.

`timescale 1ns/1ps

module tb_vga_sync_gen;

    // Shrunken raster for full-frame checks: 50 clocks/line, 33 lines/frame.
    localparam int S_HA = 32, S_HFP = 4, S_HS = 8, S_HBP = 6;
    localparam int S_VA = 24, S_VFP = 3, S_VS = 2, S_VBP = 4;
    localparam int S_FRAME = (S_HA + S_HFP + S_HS + S_HBP) * (S_VA + S_VFP + S_VS + S_VBP);

    logic        CLOCK_25 = 1'b0;
    logic        RESET_N  = 1'b1;
    logic [2:0]  color    = 3'b000;

    logic [11:0] x_a, y_a, x_b, y_b;
    logic [2:0]  rgb_a, rgb_b;
    logic        hs_a, vs_a, va_a, ft_a;
    logic        hs_b, vs_b, va_b, ft_b;

    int errors = 0;
    int checks = 0;
    int k = 0;                   // rising edges seen with RESET_N high since release
    logic [2:0] last_color = 3'b000;

    // Aggregate collectors
    bit   win_a = 1'b0;
    bit   prev_hs_a = 1'b1;
    int   hs_low_a, va_cnt_a;
    int   falls_a[$];
    bit   win_b = 1'b0;
    int   lit_b, tick_b, vs_low_b, va_cnt_b;

    always #20 CLOCK_25 = ~CLOCK_25;

    vga_sync_gen dut_a (
        .CLOCK_25     (CLOCK_25),
        .RESET_N      (RESET_N),
        .color        (color),
        .x            (x_a),
        .y            (y_a),
        .rgb          (rgb_a),
        .hsync_n      (hs_a),
        .vsync_n      (vs_a),
        .video_active (va_a),
        .frame_tick   (ft_a)
    );

    vga_sync_gen #(
        .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
        .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP)
    ) dut_b (
        .CLOCK_25     (CLOCK_25),
        .RESET_N      (RESET_N),
        .color        (color),
        .x            (x_b),
        .y            (y_b),
        .rgb          (rgb_b),
        .hsync_n      (hs_b),
        .vsync_n      (vs_b),
        .video_active (va_b),
        .frame_tick   (ft_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: counter state after n edges is simply n mod frame, split into
    // (line, pixel); registered outputs show the state one edge earlier.
    task automatic check_dut(input string nm,
                             input int ha, input int hfp, input int hs, input int hbp,
                             input int va, input int vfp, input int vs, input int vbp,
                             input int n, input logic [2:0] lc,
                             input logic [11:0] ox, input logic [11:0] oy,
                             input logic [2:0] orgb, input logic ohs, input logic ovs,
                             input logic ova, input logic oft);
        int ht, vt, c, h, v, ex, ey;
        logic [2:0] ergb;
        logic ehs, evs, eva, eft, pa;
        ht = ha + hfp + hs + hbp;
        vt = va + vfp + vs + vbp;
        c  = n % (ht * vt);
        h  = c % ht;
        v  = c / ht;
        ex = (h < ha && v < va) ? h + 1 : 0;
        ey = (h < ha && v < va) ? v + 1 : 0;
        if (n == 0) begin
            ergb = 3'b000; ehs = 1'b1; evs = 1'b1; eva = 1'b0; eft = 1'b0;
        end else begin
            c  = (n - 1) % (ht * vt);
            h  = c % ht;
            v  = c / ht;
            pa = (h < ha) && (v < va);
            ergb = pa ? lc : 3'b000;
            ehs  = !(h >= ha + hfp && h < ha + hfp + hs);
            evs  = !(v >= va + vfp && v < va + vfp + vs);
            eva  = pa;
`ifdef FRAME_TICK_EN
            eft  = (h == 0) && (v == va);
`else
            eft  = 1'b0;
`endif
        end
        chk({nm, ".x"},            32'(ox),   32'(ex));
        chk({nm, ".y"},            32'(oy),   32'(ey));
        chk({nm, ".rgb"},          32'(orgb), 32'(ergb));
        chk({nm, ".hsync_n"},      32'(ohs),  32'(ehs));
        chk({nm, ".vsync_n"},      32'(ovs),  32'(evs));
        chk({nm, ".video_active"}, 32'(ova),  32'(eva));
        chk({nm, ".frame_tick"},   32'(oft),  32'(eft));
    endtask

    task automatic check_all();
        check_dut("std", 640, 16, 96, 48, 480, 10, 2, 33, k, last_color,
                  x_a, y_a, rgb_a, hs_a, vs_a, va_a, ft_a);
        check_dut("small", S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, k, last_color,
                  x_b, y_b, rgb_b, hs_b, vs_b, va_b, ft_b);
    endtask

    // One cycle per iteration: sample at the falling edge, then drive the next colour.
    task automatic run_cycles(input int n, input bit hold_white);
        for (int i = 0; i < n; i++) begin
            @(negedge CLOCK_25);
            if (RESET_N) k++;
            check_all();
            if (win_a && k >= 1 && k <= 2400) begin
                if (!hs_a) hs_low_a++;
                if (va_a) va_cnt_a++;
                if (prev_hs_a && !hs_a) falls_a.push_back(k);
            end
            prev_hs_a = hs_a;
            if (win_b) begin
                if (rgb_b != 3'b000) lit_b++;
                if (ft_b) tick_b++;
                if (!vs_b) vs_low_b++;
                if (va_b) va_cnt_b++;
            end
            color = hold_white ? 3'b111 : 3'($urandom_range(0, 7));
            last_color = color;
        end
    endtask

    task automatic clear_a();
        hs_low_a = 0; va_cnt_a = 0; prev_hs_a = 1'b1;
        falls_a.delete();
    endtask

    task automatic check_lines_a(input string tag);
        chk({tag, ".hsync_low_3lines"}, 32'(hs_low_a), 32'(3 * 96));
        chk({tag, ".active_3lines"},    32'(va_cnt_a), 32'(3 * 640));
        chk({tag, ".hsync_falls"},      32'(falls_a.size()), 32'd3);
        if (falls_a.size() == 3) begin
            chk({tag, ".first_fall_edge"}, 32'(falls_a[0]), 32'd657);
            chk({tag, ".hsync_period0"},   32'(falls_a[1] - falls_a[0]), 32'd800);
            chk({tag, ".hsync_period1"},   32'(falls_a[2] - falls_a[1]), 32'd800);
        end
    endtask

    initial begin
        // Reset held for 10 clocks (falling edge created explicitly).
        #5 RESET_N = 1'b0;
        k = 0;
        run_cycles(10, 1'b0);
        chk("reset.x_std", 32'(x_a), 32'd1);
        chk("reset.y_std", 32'(y_a), 32'd1);

        // Release and run three small frames (covers three standard lines) with random colour.
        clear_a();
        win_a = 1'b1;
        RESET_N = 1'b1;
        k = 0;
        run_cycles(3 * S_FRAME, 1'b0);
        win_a = 1'b0;
        check_lines_a("lines");

        // Hold white for one full small frame: lit cycles equal the active area.
        run_cycles(1, 1'b1);
        lit_b = 0; tick_b = 0; vs_low_b = 0; va_cnt_b = 0;
        win_b = 1'b1;
        run_cycles(S_FRAME, 1'b1);
        win_b = 1'b0;
        chk("frame.lit_cycles",    32'(lit_b),    32'(S_HA * S_VA));
        chk("frame.active_cycles", 32'(va_cnt_b), 32'(S_HA * S_VA));
        chk("frame.vsync_low",     32'(vs_low_b), 32'(S_VS * (S_HA + S_HFP + S_HS + S_HBP)));
`ifdef FRAME_TICK_EN
        chk("frame.ticks",         32'(tick_b),   32'd1);
`else
        chk("frame.ticks",         32'(tick_b),   32'd0);
`endif

        // Advance to pixel 10 of line 15 of the small raster (inside active video).
        for (int i = 0; i < S_FRAME && (k % S_FRAME) != 15 * 50 + 10; i++) begin
            run_cycles(1, 1'b0);
        end
        chk("midreset.reached_point", 32'(k % S_FRAME), 32'(15 * 50 + 10));

        // Asynchronous reset mid-cycle: outputs must drop before any clock edge.
        @(posedge CLOCK_25);
        #10 RESET_N = 1'b0;
        k = 0;
        #1 check_all();
        run_cycles(3, 1'b0);

        // Restart: standard timing must repeat from (1,1).
        clear_a();
        win_a = 1'b1;
        RESET_N = 1'b1;
        run_cycles(2500, 1'b0);
        win_a = 1'b0;
        check_lines_a("restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
